audio_clk_nco: RTL
==================

Name: audio_clk_nco

Overview:
- Parametrised successor to the single fixed-frequency audio PLL: a multi-channel fractional clock-enable generator built on phase accumulators.
- Generates NUM_CH independent clock-enable streams from one fabric clock. Each stream's rate is runtime-programmable, e.g. 24.576 MHz / 22.5792 MHz MCLK enables or 48 kHz / 44.1 kHz sample enables from 50 MHz.
- Sits in sys/ beside the audio path and feeds the I2S/SPDIF/sigma-delta blocks.
- Provides a locked indication that behaves like a PLL lock across reset and rate changes.

Parameters:
- ACC_W, 32, accumulator and increment width in bits; ce rate = f_refclk * inc / 2^ACC_W.
- NUM_CH, 2, number of independent NCO channels (1..8).
- INC_DEFAULT, 32'd2111062325, increment loaded into every channel on reset (24.576 MHz from 50 MHz).
- LOCK_CYCLES, 16, cycles after reset or rate load before locked asserts (>=1).

Ports:
- refclk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- inc_in  in  NUM_CH*ACC_W  new increments; channel k occupies bits [k*ACC_W +: ACC_W].
- inc_valid  in  1  load request; sampled every cycle, with no back-pressure.
- ce_out  out  NUM_CH  one-cycle clock-enable pulse per channel.
- locked  out  1  high when all channels have run LOCK_CYCLES cycles since the last reset or load.

Behaviour:
- Reset, checked before anything else each cycle:
  - acc[k] = 0 and inc_reg[k] = INC_DEFAULT for all k.
  - ce_out = 0, locked = 0, lock_cnt = 0.
- Per-channel datapath (every cycle, not in reset, no load):
  - {carry, acc_next} = acc + inc_reg, computed at ACC_W+1 bits.
  - acc <= acc_next, truncated to ACC_W bits (wraps modulo 2^ACC_W).
  - ce_out[k] <= carry, so the pulse is registered with 1-cycle latency after the overflowing add.
- inc_reg == 0:
  - Channel is stopped; ce_out[k] stays 0.
  - The channel still counts toward locked.
- Load (inc_valid=1 and rst=0):
  - All inc_reg are updated from inc_in.
  - All acc are cleared to 0 for phase alignment.
  - ce_out <= 0 in that cycle; lock_cnt <= 0; locked <= 0.
  - First add with the new increment happens in the following cycle.
- inc_valid held high: every cycle is a load, so the accumulators stay at 0 and locked stays 0.
- Lock state machine, two states:
  - LOCKING: lock_cnt increments each cycle. When lock_cnt == LOCK_CYCLES-1, go to LOCKED and set locked <= 1.
  - LOCKED: locked stays 1 until rst or a load, either of which returns the state to LOCKING.
- Timing with inc = 2^(ACC_W-1), load at cycle N:
  - Add at N+1 gives acc = 2^(ACC_W-1) with no carry.
  - Add at N+2 overflows; ce_out is high in cycle N+3.
  - Thereafter ce_out pulses every 2 cycles.
- Reset mid-operation:
  - Discards any pending load; custom increments revert to INC_DEFAULT.
  - rst and inc_valid high together: rst wins.
- Jitter: the long-run pulse count over M cycles equals floor(M*inc/2^ACC_W), within ±1.

Optional Feature:
- Macro AUDIO_CLK_NCO_SQWAVE_EN.
- When defined:
  - Adds output clk_out [NUM_CH], reset to 0.
  - clk_out[k] toggles on each ce_out[k] pulse, in the cycle after the pulse, giving a 50%-average square wave at half the ce rate (e.g. for LRCLK/BCLK).
  - A load clears clk_out to 0.
- When undefined: the port and its toggle flops do not exist; all other behaviour is identical.

Decomposition:
- Package audio_clk_nco_pkg holds:
  - ACC_W_DEF.
  - Increment constants for 50 MHz refclk: INC_MCLK_48K (24.576 MHz) = 2111062325; INC_MCLK_44K1 (22.5792 MHz); INC_FS_48K (48 kHz); INC_FS_44K1 (44.1 kHz).
  - Lock-state typedef {LOCKING, LOCKED}.
- Sub-module nco_channel, instantiated NUM_CH times by generate:
  - Holds one acc, the adder and the ce flop.
  - Takes a load/clear input and the optional square-wave toggle.
- The top level holds the inc registers, lock counter/FSM and port packing.

Test Plan:
- Reset release with default increment, 50000 cycles -> locked high at cycle 16 after rst drops; ce_out[0] count = 24576 ±1.
- Load ch0 inc = 2^31 at cycle N -> ce_out[0]=0 at N+1 and N+2, high at N+3, N+5, N+7...; locked low N+1..N+16, high from N+17.
- Load ch0 = 2^31, ch1 = 2^30 simultaneously -> ch0 pulses every 2 cycles and ch1 every 4; first pulses at N+3 and N+5, phase-aligned.
- Load inc = 0 on ch1 -> ce_out[1] never asserts over 1000 cycles; locked still asserts after LOCK_CYCLES.
- rst asserted together with inc_valid mid-run -> next cycle all outputs 0; after release ch0 resumes the INC_DEFAULT pattern.
- With AUDIO_CLK_NCO_SQWAVE_EN and inc = 2^31 -> clk_out[0] toggles every 2 cycles, period 4; cleared to 0 on load.

Source files
------------

// File: rtl/audio_clk_nco_pkg.sv
// audio_clk_nco_pkg: shared constants and lock-state type for the audio clock NCO.
package audio_clk_nco_pkg;
  localparam int ACC_W_DEF = 32;
  // Increments for a 50 MHz refclk: inc = f_out / 50e6 * 2^32
  localparam logic [31:0] INC_MCLK_48K  = 32'd2111062325;
  localparam logic [31:0] INC_MCLK_44K1 = 32'd1939538511;
  localparam logic [31:0] INC_FS_48K    = 32'd4123169;
  localparam logic [31:0] INC_FS_44K1   = 32'd3788161;
  typedef enum logic {LOCKING, LOCKED} lock_state_t;
endpackage

// File: rtl/audio_clk_nco_channel.sv
// nco_channel: one phase accumulator with registered carry as clock enable (AUDIO_CLK_NCO_SQWAVE_EN adds sq).
module nco_channel #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
`ifdef AUDIO_CLK_NCO_SQWAVE_EN
  ,
  output logic             sq
`endif
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      acc <= sum[ACC_W-1:0];
      ce  <= sum[ACC_W];
    end
  end
`ifdef AUDIO_CLK_NCO_SQWAVE_EN
  always_ff @(posedge clk) begin
    if (rst || clr) sq <= 1'b0;
    else if (ce) sq <= ~sq;
  end
`endif
endmodule

// File: rtl/audio_clk_nco.sv
// audio_clk_nco: multi-channel fractional clock-enable generator with PLL-like lock (AUDIO_CLK_NCO_SQWAVE_EN adds clk_out).
module audio_clk_nco
  import audio_clk_nco_pkg::*;
#(
  parameter int              ACC_W       = ACC_W_DEF,
  parameter int              NUM_CH      = 2,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_MCLK_48K),
  parameter int              LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*ACC_W-1:0] inc_in,
  input  logic                    inc_valid,
  output logic [NUM_CH-1:0]       ce_out,
`ifdef AUDIO_CLK_NCO_SQWAVE_EN
  output logic [NUM_CH-1:0]       clk_out,
`endif
  output logic                    locked
);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  logic [ACC_W-1:0] inc_reg [NUM_CH];
  lock_state_t      state, state_d;
  logic [CW-1:0]    lock_cnt, lock_cnt_d;
  always_ff @(posedge refclk) begin
    for (int k = 0; k < NUM_CH; k++)
      if (rst) inc_reg[k] <= INC_DEFAULT;
      else if (inc_valid) inc_reg[k] <= inc_in[k*ACC_W +: ACC_W];
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= LOCKING;
      lock_cnt <= '0;
    end else begin
      state    <= state_d;
      lock_cnt <= lock_cnt_d;
    end
  end
  always_comb begin
    state_d    = state;
    lock_cnt_d = lock_cnt;
    if (inc_valid) begin
      state_d    = LOCKING;
      lock_cnt_d = '0;
    end else if (state == LOCKING) begin
      state_d    = (lock_cnt == CW'(LOCK_CYCLES - 1)) ? LOCKED : LOCKING;
      lock_cnt_d = lock_cnt + 1'b1;
    end
  end
  assign locked = (state == LOCKED);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    nco_channel #(.ACC_W(ACC_W)) u_ch (
      .clk(refclk),
      .rst(rst),
      .clr(inc_valid),
      .inc(inc_reg[k]),
      .ce (ce_out[k])
`ifdef AUDIO_CLK_NCO_SQWAVE_EN
      ,
      .sq (clk_out[k])
`endif
    );
  end
endmodule
